// File: rtl/rst_sequencer.sv
// rst_sequencer: reset release synchronizer, staged memory/core reset sequencing, run gating and watchdog.
module rst_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MEM_HOLD    = 16,
  parameter int unsigned CPU_HOLD    = 8,
  parameter logic [31:0] WDT_LIMIT   = 32'd100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy_en,
  input  logic        halt_req,
  output logic        mem_rst,
  output logic        cpu_rst,
  output logic        cpu_rdy,
  output logic        running,
  output logic        timeout,
  output logic [31:0] cycle_cnt
);
  typedef enum logic [2:0] {S_RESET, S_MEM, S_CPU, S_RUN, S_HALT} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic [31:0] hold, hold_d, cnt_d;
  logic tmo_d, srst_n;
  assign srst_n = sync[SYNC_STAGES-1];
  assign cpu_rdy = running & rdy_en;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  always_comb begin
    state_d = state;
    hold_d  = hold + 32'd1;
    cnt_d   = cycle_cnt;
    tmo_d   = timeout;
    case (state)
      S_RESET: begin
        hold_d = '0;
        if (srst_n) state_d = S_MEM;
      end
      S_MEM: if (hold == MEM_HOLD - 1) begin
        state_d = S_CPU;
        hold_d  = '0;
      end
      S_CPU: if (hold == CPU_HOLD - 1) begin
        state_d = S_RUN;
        hold_d  = '0;
      end
      S_RUN: begin
        hold_d = '0;
        if (rdy_en) cnt_d = cycle_cnt + 32'd1;
        // an explicit halt request outranks watchdog expiry on the same edge
        if (halt_req) state_d = S_HALT;
        else if (WDT_LIMIT != 0 && rdy_en && cnt_d == WDT_LIMIT) begin
          state_d = S_HALT;
          tmo_d   = 1'b1;
        end
      end
      default: hold_d = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_RESET;
      hold      <= '0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
      mem_rst   <= 1'b1;
      cpu_rst   <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_d;
      hold      <= hold_d;
      cycle_cnt <= cnt_d;
      timeout   <= tmo_d;
      mem_rst   <= state_d inside {S_RESET, S_MEM};
      cpu_rst   <= state_d inside {S_RESET, S_MEM, S_CPU};
      running   <= state_d == S_RUN;
    end
endmodule
